// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780 LCD path (bus writer and
// command/character sequencer).
//   - lcd_state_e       : bus-writer FSM states
//   - T_*_DEF           : default bus timing in 50 MHz clock cycles
//   - CMD_*             : HD44780 instruction codes used by the sequencer
//   - is_long_cmd()     : selects the 1.64 ms execution wait (clear/home)
//   - max_int()         : helper for sizing counters from timing parameters
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4
  } lcd_state_e;

  localparam int DATA_W = 8;

  localparam int T_SETUP_DEF     = 2;
  localparam int T_EN_HIGH_DEF   = 16;
  localparam int T_HOLD_DEF      = 2;
  localparam int T_EXEC_DEF      = 2000;   // 40 us
  localparam int T_EXEC_LONG_DEF = 82000;  // 1.64 ms

  localparam logic [DATA_W-1:0] CMD_CLEAR        = 8'h01;
  localparam logic [DATA_W-1:0] CMD_HOME         = 8'h02;
  localparam logic [DATA_W-1:0] CMD_ENTRY        = 8'h06;
  localparam logic [DATA_W-1:0] CMD_DISP_ON      = 8'h0C;
  localparam logic [DATA_W-1:0] CMD_FUNC_8BIT_2L = 8'h38;
  localparam logic [DATA_W-1:0] CMD_DDRAM        = 8'h80;

  // Clear (0x01) and the two return-home encodings (0x02, 0x03 - bit 0 is
  // don't-care) need the long execution wait; only instructions qualify.
  function automatic logic is_long_cmd(input logic rs, input logic [DATA_W-1:0] data);
    return (!rs) && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter: loadable down-counter with an expiry strobe.
//   clk, rst  : clock and asynchronous active-high reset
//   load      : load load_val this edge (has priority over counting)
//   load_val  : number of enabled cycles until expiry
//   en        : count this edge
//   done      : high during the cycle whose edge ends the loaded interval
// A value L loaded at edge k raises done in the cycle before edge k+L, so
// a caller that reacts to done on that edge sees exactly L cycles elapse.
module lcd_delay_counter
  import lcd_pkg::*;
#(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = en && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: single-transfer HD44780 write engine.
// Accepts one {RS, DATA} word per valid/ready handshake and produces the
// timed RS/DATA setup, EN pulse, hold and post-write execution wait.
//   CLOCK_50  : 50 MHz clock
//   RESET     : asynchronous active-high reset
//   in_valid  : upstream word valid
//   in_ready  : engine idle and able to accept a word
//   in_rs     : 0 = instruction, 1 = data
//   in_data   : instruction / character byte
//   LCD_EN    : enable strobe (registered)
//   LCD_RS    : register select (registered)
//   LCD_RW    : tied low, write-only bus
//   LCD_DATA  : bus data (registered); pad-level tristate lives above
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int T_SETUP     = T_SETUP_DEF,
  parameter int T_EN_HIGH   = T_EN_HIGH_DEF,
  parameter int T_HOLD      = T_HOLD_DEF,
  parameter int T_EXEC      = T_EXEC_DEF,
  parameter int T_EXEC_LONG = T_EXEC_LONG_DEF
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_rs,
  input  logic [DATA_W-1:0] in_data,
  output logic              LCD_EN,
  output logic              LCD_RS,
  output logic              LCD_RW,
  output logic [DATA_W-1:0] LCD_DATA
);

  localparam int MAX_T = max_int(max_int(T_SETUP, T_EN_HIGH),
                                 max_int(T_HOLD, max_int(T_EXEC, T_EXEC_LONG)));
  localparam int CNT_W = $clog2(MAX_T + 1);

  lcd_state_e        state_q, state_d;
  logic              ready_q, ready_d;
  logic              en_q, en_d;
  logic              rs_q, rs_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_en;
  logic              cnt_done;

  lcd_delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay (
    .clk      (CLOCK_50),
    .rst      (RESET),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .done     (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    en_d     = en_q;
    rs_d     = rs_q;
    data_d   = data_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // ready rises on the first edge out of reset; the handshake uses the
        // registered ready so no input reaches an output combinationally.
        ready_d = 1'b1;
        if (in_valid && ready_q) begin
          rs_d     = in_rs;
          data_d   = in_data;
          ready_d  = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(T_SETUP);
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          en_d     = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(T_EN_HIGH);
          state_d  = PULSE;
        end
      end
      PULSE: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          en_d     = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(T_HOLD);
          state_d  = HOLD;
        end
      end
      HOLD: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          cnt_load = 1'b1;
          cnt_val  = is_long_cmd(rs_q, data_q) ? CNT_W'(T_EXEC_LONG) : CNT_W'(T_EXEC);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  assign in_ready = ready_q;
  assign LCD_EN   = en_q;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = 1'b0;
  assign LCD_DATA = data_q;

endmodule
